fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/ifid_latch.sv | 48 ++++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU types for the fetch stage (word type, fetch FSM
//               states, bubble constant, address alignment helper).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t c_NOP     = 32'h0000_0000;
    localparam word_t c_PC_STEP = 32'd4;

    // Instruction addresses are word aligned; drop the byte offset.
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifid_latch.sv
`default_nettype none
// ============================================================================
// Module      : ifid_latch
// Description : IF/ID pipeline register. flush inserts a bubble and wins over
//               en; with neither asserted the contents are held.
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_latch
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  flush,
    input  word_t instr,
    input  word_t pc4,
    input  logic  valid,
    output word_t ifid_instr,
    output word_t ifid_pc4,
    output logic  ifid_valid
);

    word_t r_instr;
    word_t r_pc4;
    logic  r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= c_NOP;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_instr <= c_NOP;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_instr <= instr;
            r_pc4   <= pc4;
            r_valid <= valid;
        end
    end

    assign ifid_instr = r_instr;
    assign ifid_pc4   = r_pc4;
    assign ifid_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch: PC register, redirect/halt FSM and IF/ID
//               latch. Define FETCH_PERF_EN to add fetch/stall perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall_ifid,
    input  logic        flush_ifid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    word_t        r_pc;
    word_t        r_pend_pc;

    word_t w_pc_next;
    word_t w_pend_next;
    word_t w_pc_plus4;
    word_t w_target;
    logic  w_active;
    logic  w_redirect_now;
    logic  w_fetch;
    logic  w_lat_en;
    logic  w_lat_flush;
    word_t w_lat_instr;
    word_t w_lat_pc4;
    logic  w_lat_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= RUN;
            r_pc      <= PC_INIT;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_pend_pc <= w_pend_next;
        end
    end

    // Halt outranks every other request, including a same-cycle redirect.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (halt)
                    w_state_next = HALTED;
                else if (redirect_valid && stall_ifid)
                    w_state_next = PEND;
            end
            PEND: begin
                if (halt)
                    w_state_next = HALTED;
                else if (!stall_ifid)
                    w_state_next = RUN;
            end
            HALTED:  w_state_next = HALTED;
            default: w_state_next = RUN;
        endcase
    end

    always_comb begin
        imemREN        = (r_state != HALTED);
        w_active       = (r_state != HALTED) && !halt;
        w_pc_plus4     = r_pc + c_PC_STEP;
        // A live redirect is newer than a buffered one, so it wins.
        w_target       = redirect_valid ? redirect_pc : r_pend_pc;
        w_redirect_now = w_active && !stall_ifid && (redirect_valid || (r_state == PEND));
        w_fetch        = w_active && !stall_ifid && !w_redirect_now && ihit;

        w_pc_next = r_pc;
        if (w_redirect_now)
            w_pc_next = align_word(w_target);
        else if (w_fetch)
            w_pc_next = w_pc_plus4;

        w_pend_next = r_pend_pc;
        if (w_active && stall_ifid && redirect_valid)
            w_pend_next = redirect_pc;

        // When halting, reload the latch with its own contents but drop valid.
        w_lat_flush = w_active && (flush_ifid || (!stall_ifid && !w_fetch));
        w_lat_en    = !w_active || w_fetch;
        w_lat_instr = w_active ? iload      : ifid_instr;
        w_lat_pc4   = w_active ? w_pc_plus4 : ifid_pc4;
        w_lat_valid = w_active;
    end

    assign imemaddr = r_pc;

    ifid_latch u_ifid_latch (
        .clk        (CLK),
        .rst        (RST),
        .en         (w_lat_en),
        .flush      (w_lat_flush),
        .instr      (w_lat_instr),
        .pc4        (w_lat_pc4),
        .valid      (w_lat_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_fetch)
                r_perf_fetch <= r_perf_fetch + 32'd1;
            if ((r_state != HALTED) && (!ihit || stall_ifid))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Scoreboard bench for fetch_stage: directed scenarios followed
//               by random traffic checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ihit = 1'b0;
    logic [31:0] iload = '0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall_ifid = 1'b0;
    logic        flush_ifid = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_stage #(.PC_INIT(PC_INIT)) dut (
        .CLK            (clk),
        .RST            (rst),
        .ihit           (ihit),
        .iload          (iload),
        .imemREN        (imemREN),
        .imemaddr       (imemaddr),
        .stall_ifid     (stall_ifid),
        .flush_ifid     (flush_ifid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .ifid_instr     (ifid_instr),
        .ifid_pc4       (ifid_pc4),
        .ifid_valid     (ifid_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        ren;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural model: plain architectural variables, no state encoding.
    logic [31:0] m_pc, m_target, m_instr, m_pc4, m_fc, m_sc;
    bit          m_pend, m_halted, m_valid;

    task automatic model_bubble();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit hit, input bit st, input bit fl,
                              input bit rv, input logic [31:0] rpc, input bit hl,
                              input logic [31:0] il);
        if (r) begin
            m_pc = PC_INIT; m_target = '0; m_pend = 0; m_halted = 0;
            m_fc = '0; m_sc = '0;
            model_bubble();
            return;
        end
        if (!m_halted && (!hit || st))
            m_sc = m_sc + 32'd1;
        if (m_halted || hl) begin
            m_halted = 1;
            m_pend   = 0;
            m_valid  = 1'b0;
            return;
        end
        if (st) begin
            if (rv) begin
                m_pend   = 1;
                m_target = rpc;
            end
        end else if (rv || m_pend) begin
            m_pc   = (rv ? rpc : m_target) & 32'hFFFF_FFFC;
            m_pend = 0;
            model_bubble();
        end else if (hit) begin
            m_instr = il;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_fc    = m_fc + 32'd1;
        end else begin
            model_bubble();
        end
        if (fl)
            model_bubble();
    endtask

    task automatic step(input bit r, input bit hit, input bit st, input bit fl,
                        input bit rv, input logic [31:0] rpc, input bit hl,
                        input logic [31:0] il);
        exp_t e;
        @(negedge clk);
        rst = r; ihit = hit; stall_ifid = st; flush_ifid = fl;
        redirect_valid = rv; redirect_pc = rpc; halt = hl; iload = il;
        model_step(r, hit, st, fl, rv, rpc, hl, il);
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
        e.ren = !m_halted; e.fcnt = m_fc; e.scnt = m_sc;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    // Monitor: every cycle the DUT presents a new state; compare it after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imemaddr",   imemaddr,   e.pc);
                chk("imemREN",    {31'b0, imemREN},    {31'b0, e.ren});
                chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
                chk("ifid_instr", ifid_instr, e.instr);
                if (e.valid)
                    chk("ifid_pc4", ifid_pc4, e.pc4);
`ifdef FETCH_PERF_EN
                chk("perf_fetch_cnt", perf_fetch_cnt, e.fcnt);
                chk("perf_stall_cnt", perf_stall_cnt, e.scnt);
`endif
            end
        end
    end

    initial begin
        // Straight-line fetch from reset.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 0, 0, 0, 0, 32'hA000_0000 + i);

        // Miss at PC=8 for four cycles, then a hit.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 32'h1111_0000);
        step(0, 1, 0, 0, 0, 0, 0, 32'h1111_0004);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        step(0, 1, 0, 0, 0, 0, 0, 32'h1111_0008);

        // Redirect buffered under stall, released when stall drops.
        step(0, 1, 1, 0, 1, 32'h0000_0100, 0, 32'h2222_0000);
        step(0, 1, 1, 0, 0, 0, 0, 32'h2222_0004);
        step(0, 1, 0, 0, 0, 0, 0, 32'h2222_0008);
        step(0, 1, 0, 0, 0, 0, 0, 32'h2222_000C);

        // Stall and flush together leave a bubble.
        step(0, 1, 1, 1, 0, 0, 0, 32'h3333_0000);

        // PC wrap, with an unaligned redirect target.
        step(0, 1, 0, 0, 1, 32'hFFFF_FFFF, 0, 32'h4444_0000);
        step(0, 1, 0, 0, 0, 0, 0, 32'h4444_0004);
        step(0, 1, 0, 0, 0, 0, 0, 32'h4444_0008);

        // Halt wins over a simultaneous redirect; reset recovers.
        step(0, 1, 0, 0, 1, 32'h0000_0200, 1, 32'h5555_0000);
        for (int i = 0; i < 10; i++)
            step(0, i[0], i[1], 0, i[2], 32'h0000_0300, 0, $urandom);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 32'h6666_0000);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom % 60) == 0, ($urandom % 4) != 0, ($urandom % 4) == 0,
                 ($urandom % 8) == 0, ($urandom % 6) == 0, $urandom,
                 ($urandom % 80) == 0, $urandom);

        @(negedge clk);
        rst = 0; ihit = 0; stall_ifid = 0; flush_ifid = 0;
        redirect_valid = 0; halt = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
